// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin arbiter sharing one sequential Booth multiplier core
// Optional feature macro: BOOTH_ARB_BYPASS_EN (answers a==0, b==0 and b==1 without using the core)
module booth_mul_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 33,
  parameter int ID_W       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_reset,
  input  logic [2*WIDTH-1:0]       mul_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_result,
  output logic                     busy
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic                 mul_reset_q, mul_reset_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]   rsp_result_q, rsp_result_d;

  logic [N_REQ-1:0]     valid_m;
  logic                 sel_found;
  logic [ID_W-1:0]      sel_idx;
  logic [WIDTH-1:0]     sel_a, sel_b;

  // No grant can be offered while reset is held, even though the state reads IDLE.
  assign valid_m = req_valid & {N_REQ{~reset}};

  // Round-robin pick: first valid at or above rr_ptr, otherwise first valid from index 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!sel_found && valid_m[j] && (ID_W'(j) >= rr_ptr_q)) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(j);
        sel_a     = req_a[j*WIDTH +: WIDTH];
        sel_b     = req_b[j*WIDTH +: WIDTH];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!sel_found && valid_m[j]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(j);
        sel_a     = req_a[j*WIDTH +: WIDTH];
        sel_b     = req_b[j*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and output logic for the accept / restart / count / respond sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_reset_d  = mul_reset_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        mul_reset_d = 1'b0;
        if (sel_found) begin
          req_ready = N_REQ'(1) << sel_idx;
          mul_a_d   = sel_a;
          mul_b_d   = sel_b;
          grant_d   = sel_idx;
`ifdef BOOTH_ARB_BYPASS_EN
          if ((sel_a == '0) || (sel_b == '0)) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = sel_idx;
            rsp_result_d = '0;
            state_d      = RESP;
          end else if (sel_b == WIDTH'(1)) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = sel_idx;
            rsp_result_d = {{WIDTH{sel_a[WIDTH-1]}}, sel_a};
            state_d      = RESP;
          end else begin
            mul_reset_d = 1'b1;
            state_d     = START;
          end
`else
          mul_reset_d = 1'b1;
          state_d     = START;
`endif
        end
      end
      START: begin
        mul_reset_d = 1'b0;
        cnt_d       = CNT_W'(MUL_CYCLES - 1);
        state_d     = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_result_d = mul_result;
          rsp_id_d     = grant_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset holds the core in restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_reset_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_reset_q  <= mul_reset_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_reset  = mul_reset_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - randomized self-checking bench for booth_mul_arbiter
`timescale 1ns/1ps
module tb_booth_mul_arbiter;

  localparam int N_REQ      = 4;
  localparam int W          = 32;
  localparam int MUL_CYCLES = 33;
  localparam int ID_W       = 2;
  localparam logic [2*W-1:0] POISON = {(W/4){8'hA5}};

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     req_valid, req_ready;
  logic [N_REQ*W-1:0]   req_a, req_b;
  logic [W-1:0]         mul_a, mul_b;
  logic                 mul_reset;
  logic [2*W-1:0]       mul_result, rsp_result;
  logic                 rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0]      rsp_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.N_REQ(N_REQ), .WIDTH(W), .MUL_CYCLES(MUL_CYCLES), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_reset(mul_reset),
    .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
  );

  // Core stand-in: product only becomes visible MUL_CYCLES cycles after restart release.
  int core_cnt = 0;
  logic signed [2*W-1:0] core_sa, core_sb;
  always @(posedge clk) begin
    if (mul_reset) core_cnt <= 0;
    else if (core_cnt < 100000) core_cnt <= core_cnt + 1;
  end
  assign core_sa    = {{W{mul_a[W-1]}}, mul_a};
  assign core_sb    = {{W{mul_b[W-1]}}, mul_b};
  assign mul_result = (!mul_reset && core_cnt >= MUL_CYCLES - 1) ? core_sa * core_sb : POISON;

  // Requester side and reference model state
  logic          pend [N_REQ];
  logic [W-1:0]  pa [N_REQ];
  logic [W-1:0]  pb [N_REQ];
  logic          refill;
  logic          rdy_drv;

  logic          m_idle, m_resp, m_full;
  int            m_rr, m_grant, m_edges, m_acc_edge, m_due;
  logic [W-1:0]  m_a, m_b;
  logic [2*W-1:0] m_exp;

  int            log_id [$];
  logic [2*W-1:0] log_res [$];

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic signed [2*W-1:0] sext(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      default: return $urandom();
    endcase
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_resp = 1'b0; m_full = 1'b0;
    m_rr = 0; m_grant = 0; m_edges = 0; m_acc_edge = -1; m_due = -1;
    m_a = '0; m_b = '0; m_exp = '0;
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", req_ready, '0);
    check("rst_busy", busy, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_mul_reset", mul_reset, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic run_cycle();
    logic [N_REQ-1:0] exp_ready;
    logic             hs;
    int               g;
    logic [2*W-1:0]   got_res;
    int               got_id;
    logic             byp;
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i]        = pend[i];
      req_a[i*W +: W]     = pa[i];
      req_b[i*W +: W]     = pb[i];
    end
    rsp_ready = rdy_drv;
    #1;
    exp_ready = '0;
    g = -1;
    if (m_idle) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (g < 0 && pend[(m_rr + k) % N_REQ]) g = (m_rr + k) % N_REQ;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, !m_idle);
    check("rsp_valid", rsp_valid, m_resp);
    if (m_resp) begin
      check("rsp_id", rsp_id, m_grant);
      check("rsp_result", rsp_result, m_exp);
    end
    check("mul_reset", mul_reset, (m_edges == 0) || (m_full && m_edges == m_acc_edge));
    check("mul_a", mul_a, m_a);
    check("mul_b", mul_b, m_b);
    hs      = m_resp && rdy_drv;
    got_id  = int'(rsp_id);
    got_res = rsp_result;
    @(posedge clk);
    m_edges++;
    if (hs) begin
      m_resp = 1'b0;
      m_idle = 1'b1;
      m_rr   = (m_grant + 1) % N_REQ;
      log_id.push_back(got_id);
      log_res.push_back(got_res);
    end
    if (!m_idle && !m_resp && m_edges == m_due) m_resp = 1'b1;
    if (g >= 0) begin
      m_idle     = 1'b0;
      m_grant    = g;
      m_a        = pa[g];
      m_b        = pb[g];
      m_acc_edge = m_edges;
      m_exp      = sext(pa[g]) * sext(pb[g]);
`ifdef BOOTH_ARB_BYPASS_EN
      byp = (pa[g] == '0) || (pb[g] == '0) || (pb[g] == W'(1));
`else
      byp = 1'b0;
`endif
      m_full = !byp;
      m_due  = m_edges + (byp ? 1 : 1 + MUL_CYCLES);
      if (!refill) pend[g] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_until_quiet(input int budget);
    int   n;
    logic busy_any;
    logic timed_out;
    n = 0;
    timed_out = 1'b0;
    forever begin
      busy_any = !m_idle;
      for (int i = 0; i < N_REQ; i++) busy_any |= pend[i];
      if (!busy_any) break;
      if (n >= budget) begin timed_out = 1'b1; break; end
      run_cycle();
      n++;
    end
    check("quiet_timeout", timed_out, 0);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[i] = 1'b1; pa[i] = a; pb[i] = b;
  endtask

  initial begin
    int n;
    logic timed_out;
    refill  = 1'b0;
    rdy_drv = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin pa[i] = '0; pb[i] = '0; end
    model_reset();
    reset     = 1'b1;
    req_valid = 4'b0110;
    req_a     = '1;
    req_b     = '1;
    rsp_ready = 1'b1;
    #3;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b0;

    // Single requester 0: 50 * -40
    log_id.delete(); log_res.delete();
    set_req(0, W'(50), W'(-40));
    run_until_quiet(200);
    check("t1_count", log_id.size(), 1);
    check("t1_id", log_id[0], 0);
    check("t1_res", log_res[0], 64'(-2000));

    // Reset asserted while WAIT counter reads 10
    set_req(2, W'(3), W'(4));
    n = 0;
    while (m_idle && n < 20) begin run_cycle(); n++; end
    while (m_edges < m_acc_edge + 23 && n < 100) begin run_cycle(); n++; end
    check("t5_reach_wait", !m_idle && !m_resp, 1);
    #2;
    reset = 1'b1;
    req_valid = 4'b0010;
    #1;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    log_id.delete(); log_res.delete();
    set_req(3, W'(98756), W'(0));
    run_until_quiet(200);
    check("t5_count", log_id.size(), 1);
    check("t5_id", log_id[0], 3);
    check("t5_res", log_res[0], 0);

    // Requesters 1 and 3 together with rr_ptr back at 0
    log_id.delete(); log_res.delete();
    set_req(1, W'(90), W'(70));
    set_req(3, W'(-80), W'(-65));
    run_until_quiet(300);
    check("t2_count", log_id.size(), 2);
    check("t2_id0", log_id[0], 1);
    check("t2_res0", log_res[0], 64'(6300));
    check("t2_id1", log_id[1], 3);
    check("t2_res1", log_res[1], 64'(5200));

    // All four continuously valid: service order 0,1,2,3,0
    log_id.delete(); log_res.delete();
    refill = 1'b1;
    set_req(0, W'(-10), W'(325));
    set_req(1, W'(-500), W'(2000));
    set_req(2, W'(-999), W'(999));
    set_req(3, W'(98765), W'(1));
    n = 0;
    while (log_id.size() < 5 && n < 600) begin run_cycle(); n++; end
    refill = 1'b0;
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
    run_until_quiet(200);
    check("t3_count", log_id.size() >= 5, 1);
    check("t3_id0", log_id[0], 0);
    check("t3_id1", log_id[1], 1);
    check("t3_id2", log_id[2], 2);
    check("t3_id3", log_id[3], 3);
    check("t3_id4", log_id[4], 0);
    check("t3_res0", log_res[0], 64'(-3250));
    check("t3_res1", log_res[1], 64'(-1000000));
    check("t3_res2", log_res[2], 64'(-998001));
    check("t3_res3", log_res[3], 64'(98765));

    // Backpressure: hold rsp_ready low for 10 cycles in RESP
    log_id.delete(); log_res.delete();
    for (int i = 0; i < N_REQ; i++) set_req(i, W'(1000 + i), W'(-3 - i));
    n = 0;
    timed_out = 1'b0;
    while (!m_resp) begin
      if (n >= 100) begin timed_out = 1'b1; break; end
      run_cycle(); n++;
    end
    check("t4_resp_timeout", timed_out, 0);
    rdy_drv = 1'b0;
    repeat (10) run_cycle();
    check("t4_no_early_rsp", log_id.size(), 0);
    rdy_drv = 1'b1;
    run_until_quiet(400);
    check("t4_count", log_id.size(), 4);

    // Bypass candidates (full path when the feature is absent)
    log_id.delete(); log_res.delete();
    set_req(2, W'(98756), W'(0));
    run_until_quiet(200);
    set_req(1, W'(-7), W'(1));
    run_until_quiet(200);
    check("t6_count", log_id.size(), 2);
    check("t6_res0", log_res[0], 0);
    check("t6_res1", log_res[1], 64'(-7));

    // Randomized traffic with drops and random response backpressure
    log_id.delete(); log_res.delete();
    n = 0;
    while (log_id.size() < 30 && n < 4000) begin
      rdy_drv = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 7) == 0) set_req(i, pick(), pick());
      end
      run_cycle();
      n++;
    end
    rdy_drv = 1'b1;
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
    run_until_quiet(200);
    check("rand_count", log_id.size() >= 30, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
